// File: rtl/grid_io_cfg_top.sv
// Perimeter I/O tile: NUM_PADS GPIO pads whose per-pad mode (dir, inv, in_en) is
// shifted in over the ccff chain and applied atomically by a checked load strobe.
module grid_io_cfg_top #(
  parameter int NUM_PADS = 8,
  parameter int CFG_BITS = 3
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_load,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [0:NUM_PADS-1] outpad,
  output logic [0:NUM_PADS-1] inpad,
  inout  wire  [0:NUM_PADS-1] gfpga_pad_GPIO_PAD
);

  localparam int TOTAL = NUM_PADS * CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);

  logic [TOTAL-1:0] sr_reg;
  logic [TOTAL-1:0] sr_next;
  logic [TOTAL-1:0] act_reg;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             err_reg;
  logic             frame_full;
  logic             load_ok;

  assign frame_full = (cnt_reg == CW'(TOTAL));
  assign load_ok    = ccff_load && frame_full;

  // Bit k of sr_reg is chain position k; new data enters at 0 and exits at TOTAL-1.
  always_comb begin
    sr_next = sr_reg;
    if (ccff_en) begin
      sr_next = {sr_reg[TOTAL-2:0], ccff_head};
    end
  end

  // An accepted load restarts the frame count even if a shift lands on the same edge.
  always_comb begin
    cnt_next = cnt_reg;
    if (load_ok) begin
      cnt_next = '0;
    end else if (ccff_en && !frame_full) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sr_reg  <= '0;
      act_reg <= '0;
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      sr_reg  <= sr_next;
      cnt_reg <= cnt_next;
      if (load_ok) begin
        act_reg <= sr_reg;
      end
      if (ccff_load && !frame_full) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign ccff_tail = sr_reg[TOTAL-1];
  assign cfg_done  = frame_full;
  assign cfg_err   = err_reg;

  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic dir;
      logic inv;
      logic in_en;

      assign dir   = act_reg[CFG_BITS*gi];
      assign inv   = act_reg[CFG_BITS*gi + 1];
      assign in_en = act_reg[CFG_BITS*gi + 2];

      // With dir and in_en both set, the inversion cancels and inpad echoes outpad.
      assign gfpga_pad_GPIO_PAD[gi] = dir ? (outpad[gi] ^ inv) : 1'bz;
      assign inpad[gi] = in_en ? (gfpga_pad_GPIO_PAD[gi] ^ inv) : 1'b0;
    end
  endgenerate

endmodule

// File: doc/grid_io_cfg_top.md
# grid_io_cfg_top

Parametrised I/O grid tile: NUM_PADS bidirectional GPIO pads, each with a 3-bit configuration (output enable, polarity invert, input enable) loaded over the configuration chain. Configuration bits shift through a chain register and are applied atomically to the pads by a separate load strobe. The load is accepted only after a complete frame has been shifted; otherwise it is rejected and flagged. The tile sits on the fabric perimeter between the routing channels (outpad/inpad pins) and the chip GPIO pads, daisy-chained with its neighbours through ccff_head/ccff_tail.

## Interface
- NUM_PADS, 8: number of pads/subtiles (1..64).
- CFG_BITS, 3, fixed: bits per pad. Bit 0 = dir (1: pad driven), bit 1 = inv, bit 2 = in_en.
- Derived: TOTAL = NUM_PADS*CFG_BITS; counter width = clog2(TOTAL+1).

Ports:
- prog_clk  input  1  configuration clock; the block's only clock, rising edge.
- pReset  input  1  asynchronous, active-high reset.
- ccff_head  input  1  serial configuration data in.
- ccff_en  input  1  shift enable.
- ccff_load  input  1  apply the shifted frame to the active configuration.
- ccff_tail  output  1  serial data out; chain bit TOTAL-1, registered.
- cfg_done  output  1  high when a full frame (TOTAL shifts) is held since the last load/reset.
- cfg_err  output  1  sticky: a load was rejected.
- outpad  input  [0:NUM_PADS-1]  fabric data to drive on the pads.
- inpad  output  [0:NUM_PADS-1]  pad data to the fabric.
- gfpga_pad_GPIO_PAD  inout  [0:NUM_PADS-1]  chip pads.

## Operation
- Chain register sr[0:TOTAL-1]. Pad p owns sr[3p..3p+2] (dir, inv, in_en).
- Shift (ccff_en=1): sr[0]<=ccff_head; sr[k]<=sr[k-1]. The first bit shifted in ends at sr[TOTAL-1] after TOTAL shifts. ccff_tail = sr[TOTAL-1].
- Shift counter cnt: +1 per shift, saturating at TOTAL. Further shifts keep moving data but cnt stays at TOTAL. cfg_done = (cnt==TOTAL).
- Load (ccff_load=1):
  - If cnt==TOTAL: active config act <= sr and cnt <= 0.
  - Otherwise: act unchanged, cnt unchanged, cfg_err <= 1.
- Load and shift in the same cycle: the load test and the copied data both use the pre-edge cnt/sr. The shift then applies to sr. On an accepted load, cnt becomes 0 (not 1), so the shifted bit does not count toward the next frame.
- Pad datapath, combinational from act:
  - Pad driven = outpad[p]^inv when dir=1; high-Z when dir=0.
  - inpad[p] = in_en ? (pad^inv) : 0.
  - With dir=1 and in_en=1, inpad loops back the driven value, i.e. outpad[p].

## Timing
- Reset (async assert, state held while pReset=1):
  - sr=0, act=0, cnt=0, cfg_err=0.
  - Outputs: ccff_tail=0, cfg_done=0, cfg_err=0, all pads high-Z, inpad=0.
- Release is synchronous in effect: the first edge after pReset falls may shift or load.
- Shift latency: a bit presented on ccff_head at edge n appears on ccff_tail after edge n+TOTAL-1, with ccff_en held high on those TOTAL edges.
- Load latency: pad/inpad behaviour changes immediately after the accepting edge. No glitch window; act is a single register bank.
- cfg_done rises after the edge completing the TOTAL-th shift and falls after the accepting load edge.
- cfg_err rises after the rejecting edge and clears only on pReset.
- Reset mid-shift or mid-frame: all state returns to the reset values. A partial frame is discarded and never applied.

## Test plan
- Reset/default: assert pReset, drive pads externally with 1. Required: inpad=0, pads high-Z, ccff_tail=0, cfg_done=0, cfg_err=0.
- Full frame, NUM_PADS=8 (TOTAL=24): shift a frame giving pad0={dir1,inv0,in1}, pad1={dir0,inv1,in1}, others 0, then load.
  - Pad0 follows outpad[0]; inpad[0]=outpad[0].
  - Pad1 externally 0 -> inpad[1]=1.
  - cfg_done 1 before the load, 0 after.
- Early load: 23 shifts, then load. Required: cfg_err=1, act unchanged (pads still high-Z), cnt=23. One more shift, then load: accepted, cfg_err still 1.
- Pass-through: 24+8 shifts of the pattern 10110011…. Required: ccff_tail reproduces the first 8 bits, delayed 24 edges; cnt saturates at 24.
- Simultaneous load+shift with cnt=24: required act = pre-edge sr, cnt=0 afterwards, sr shifted by one.
- Reset mid-frame: 12 shifts, pulse pReset, 24 shifts of all-zero, load. Required: accepted, all pads high-Z, inpad=0.
